// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer:
// state encoding, digit limit and preset sanitising.
package bcd_down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp an out-of-range BCD nibble to the largest legal digit.
    function automatic logic [3:0] bcd_sanitise(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow-ripple decrement chain.
// A digit at zero wraps to nine and passes the borrow on.
module bcd_digit_dec
    import bcd_down_timer_pkg::*;
(
    input  logic [3:0] d_in,
    input  logic       borrow_in,
    output logic [3:0] d_out,
    output logic       borrow_out
);

    // Decrement when borrowed from; wrap 0 -> 9 and borrow upward.
    always_comb begin
        d_out      = d_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (d_in == 4'd0) begin
                d_out      = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                d_out = d_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with
// run/pause control and a one-cycle expiry pulse.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   Y,
    output logic                  busy,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    state_t         state;
    logic [W-1:0]   load_san;
    logic [W-1:0]   y_dec;
    logic [DIGITS:0] borrow;

    // Clamp every preset digit into 0..9.
    always_comb begin
        load_san = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_san[4*i +: 4] = bcd_sanitise(load_val[4*i +: 4]);
        end
    end

    assign borrow[0] = tick && (state == RUN);

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_dec u_dec (
            .d_in       (Y[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .d_out      (y_dec[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // Control FSM with the count register and registered flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            Y     <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            Y     <= load_san;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (Y == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state <= PAUSE;
                    end else if (tick && !borrow[DIGITS]) begin
                        Y <= y_dec;
                        if (y_dec == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed self-checking bench for bcd_down_timer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bcd_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] Y;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;

    bcd_down_timer #(.DIGITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .Y        (Y),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cyc(); cyc();
        n_chk++; if (Y !== 8'h00) begin n_fail++; $display("FAIL rst_y got %h want 00", Y); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
        rst = 1'b1;
        do_load(8'h25);
        n_chk++; if (Y !== 8'h25) begin n_fail++; $display("FAIL load_y got %h want 25", Y); end
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL load_flags got %b%b want 00", busy, done); end
    endtask

    task automatic test_borrow();
        do_load(8'h10);
        do_start();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", busy); end
        do_tick();
        n_chk++; if (Y !== 8'h09) begin n_fail++; $display("FAIL borrow_y got %h want 09", Y); end
        for (int i = 0; i < 8; i++) begin
            do_tick(); cyc();
        end
        n_chk++; if (Y !== 8'h01 || done !== 1'b0) begin n_fail++; $display("FAIL pre_zero got %h/%b want 01/0", Y, done); end
        do_tick();
        n_chk++; if (Y !== 8'h00) begin n_fail++; $display("FAIL zero_y got %h want 00", Y); end
        n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL expiry got done=%b busy=%b want 1 0", done, busy); end
        cyc();
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_expiry got done=%b busy=%b want 0 0", done, busy); end
        do_tick();
        n_chk++; if (Y !== 8'h00) begin n_fail++; $display("FAIL no_underflow got %h want 00", Y); end
    endtask

    task automatic test_pause();
        do_load(8'h05);
        do_start();
        do_tick(); do_tick();
        n_chk++; if (Y !== 8'h03) begin n_fail++; $display("FAIL pre_pause got %h want 03", Y); end
        pause = 1'b1; tick = 1'b1; cyc(); pause = 1'b0; tick = 1'b0;
        n_chk++; if (Y !== 8'h03 || busy !== 1'b1) begin n_fail++; $display("FAIL pause got %h/%b want 03/1", Y, busy); end
        for (int i = 0; i < 3; i++) do_tick();
        n_chk++; if (Y !== 8'h03) begin n_fail++; $display("FAIL paused_ticks got %h want 03", Y); end
        start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
        do_tick();
        n_chk++; if (Y !== 8'h03) begin n_fail++; $display("FAIL start_pause_tie got %h want 03", Y); end
        do_start();
        do_tick();
        n_chk++; if (Y !== 8'h02 || busy !== 1'b1) begin n_fail++; $display("FAIL resume got %h/%b want 02/1", Y, busy); end
    endtask

    task automatic test_edges();
        do_load(8'h00);
        do_start();
        n_chk++; if (done !== 1'b1 || busy !== 1'b0 || Y !== 8'h00) begin n_fail++; $display("FAIL start_zero got %b%b %h want 10 00", done, busy, Y); end
        cyc();
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL start_zero_after got %b%b want 00", done, busy); end
        do_load(8'hA7);
        n_chk++; if (Y !== 8'h97) begin n_fail++; $display("FAIL sanitise_a7 got %h want 97", Y); end
        do_load(8'hFC);
        n_chk++; if (Y !== 8'h99) begin n_fail++; $display("FAIL sanitise_fc got %h want 99", Y); end
    endtask

    task automatic test_load_run();
        do_load(8'h43);
        do_start();
        do_tick();
        n_chk++; if (Y !== 8'h42 || busy !== 1'b1) begin n_fail++; $display("FAIL run_42 got %h/%b want 42/1", Y, busy); end
        do_load(8'h15);
        n_chk++; if (Y !== 8'h15 || busy !== 1'b0) begin n_fail++; $display("FAIL load_in_run got %h/%b want 15/0", Y, busy); end
        do_tick(); do_tick();
        n_chk++; if (Y !== 8'h15) begin n_fail++; $display("FAIL idle_ticks got %h want 15", Y); end
    endtask

    task automatic test_back_to_back();
        do_load(8'h03);
        do_start();
        tick = 1'b1;
        cyc();
        n_chk++; if (Y !== 8'h02) begin n_fail++; $display("FAIL b2b_1 got %h want 02", Y); end
        cyc();
        n_chk++; if (Y !== 8'h01) begin n_fail++; $display("FAIL b2b_2 got %h want 01", Y); end
        cyc();
        n_chk++; if (Y !== 8'h00 || done !== 1'b1) begin n_fail++; $display("FAIL b2b_3 got %h/%b want 00/1", Y, done); end
        cyc();
        tick = 1'b0;
        n_chk++; if (Y !== 8'h00 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_4 got %h/%b want 00/0", Y, done); end
    endtask

    task automatic test_reset_run();
        do_load(8'h34);
        do_start();
        do_tick();
        n_chk++; if (Y !== 8'h33) begin n_fail++; $display("FAIL run_33 got %h want 33", Y); end
        rst = 1'b0; cyc(); rst = 1'b1;
        n_chk++; if (Y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rst got %h/%b%b want 00/00", Y, busy, done); end
        do_tick();
        n_chk++; if (Y !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL after_rst got %h/%b%b want 00/00", Y, busy, done); end
        cyc();
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL after_rst2 done got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_borrow();
        test_pause();
        test_edges();
        test_load_run();
        test_back_to_back();
        test_reset_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
